// File: rtl/game_pkg.sv
// Shared game definitions: direction codes, move-arbiter FSM states and the
// round-robin pick used to choose the next direction to offer.
package game_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    COOLDOWN
  } arb_state_e;

  // First set bit of req found by scanning upward from ptr, wrapping mod 4.
  // Scanning from the far end lets the nearest hit overwrite the result.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/move_arbiter_if.sv
// Move handshake into the game datapath: the arbiter offers one direction at
// a time and the datapath accepts it with move_ready.
interface move_arbiter_if;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready;

  modport master (
    output move_valid,
    output move_dir,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_dir,
    output move_ready
  );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a persistence counter. level follows the
// synchronised input only after it has disagreed for DEBOUNCE_CYCLES cycles;
// rise is high in the cycle whose clock edge will flip level from 0 to 1.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;
  logic          flip;

  assign flip = (sync2 != level) && (count == LAST_COUNT);
  assign rise = flip && !level;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreement; any cycle of agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      count <= '0;
    end else if (sync2 == level) begin
      count <= '0;
    end else if (flip) begin
      level <= sync2;
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/move_arbiter.sv
// Owns the single move port into the game datapath. Debounced button presses
// become pending requests, which are granted round-robin one at a time, with a
// lockout after every accepted move so a press yields exactly one tile step.
module move_arbiter
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LOCKOUT_CYCLES  = 2500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            btn,
  input  logic                  game_over,
  move_arbiter_if.master        mv,
  output logic [3:0]            pending,
  output logic [3:0]            btn_db
);

  // Counter is sized for at least one bit so LOCKOUT_CYCLES == 0 still elaborates.
  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LAST_COOL = LW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

  arb_state_e    state;
  logic          move_valid;
  logic [1:0]    move_dir;
  logic [1:0]    rr_ptr;
  logic [LW-1:0] cool;
  logic [3:0]    rise;
  logic [3:0]    clr;
  logic [1:0]    winner;
  logic          accept;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (btn_db[i]),
      .rise  (rise[i])
    );
  end

  assign mv.move_valid = move_valid;
  assign mv.move_dir   = move_dir;

  // game_over overrides a handshake that happens to coincide with it.
  assign accept = (state == OFFER) && move_valid && mv.move_ready && !game_over;
  assign winner = rr_pick(pending, rr_ptr);

  // One-hot clear of the direction being accepted this cycle.
  always_comb begin
    clr = '0;
    if (accept) clr[move_dir] = 1'b1;
  end

  // Latch presses as requests; a new press beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else if (game_over) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  // Grant / offer / lockout sequencing with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
      rr_ptr     <= 2'd0;
      cool       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if ((pending != 4'd0) && !game_over) begin
            move_dir   <= winner;
            move_valid <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (game_over) begin
            move_valid <= 1'b0;
            state      <= IDLE;
          end else if (accept) begin
            move_valid <= 1'b0;
            rr_ptr     <= move_dir + 2'd1;
            cool       <= '0;
            state      <= (LOCKOUT_CYCLES == 0) ? IDLE : COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cool == LAST_COOL) begin
            state <= IDLE;
          end else begin
            cool <= cool + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_arbiter.sv
// Bench for move_arbiter with short debounce/lockout intervals. Directed
// scenarios check latency, bounce rejection, arbitration order, stalls,
// game_over and async reset; a randomized phase compares the accepted move
// stream against a round-robin order model.
module tb_move_arbiter;
  import game_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned LO = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_over;
  logic [3:0] btn;
  logic [3:0] pending;
  logic [3:0] btn_db;

  move_arbiter_if mv ();

  move_arbiter #(
    .DEBOUNCE_CYCLES (DB),
    .LOCKOUT_CYCLES  (LO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .game_over (game_over),
    .mv        (mv),
    .pending   (pending),
    .btn_db    (btn_db)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int acc_dir[$];
  int unsigned acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record each handshake; it completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst && mv.move_valid && mv.move_ready && !game_over) begin
      acc_dir.push_back(int'(mv.move_dir));
      acc_cyc.push_back(cyc + 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn = 4'd0;
    game_over = 1'b0;
    mv.move_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    acc_dir.delete();
    acc_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 4'b1111;
    game_over = 1'b0;
    mv.move_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (mv.move_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", mv.move_valid);
    end
    checks++;
    if (mv.move_dir !== 2'd0) begin
      errors++; $display("FAIL reset_dir got %0d exp 0", mv.move_dir);
    end
    checks++;
    if (pending !== 4'd0) begin
      errors++; $display("FAIL reset_pending got %b exp 0000", pending);
    end
    checks++;
    if (btn_db !== 4'd0) begin
      errors++; $display("FAIL reset_btn_db got %b exp 0000", btn_db);
    end
    do_reset();
  endtask

  task automatic test_single_press();
    logic exp_db, exp_pend, exp_v;
    acc_dir.delete();
    acc_cyc.delete();
    @(posedge clk);
    #1;
    btn = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_db   = (k >= 2 + DB);
      exp_pend = (k == 2 + DB) || (k == 3 + DB);
      exp_v    = (k == 3 + DB);
      checks++;
      if (btn_db !== {3'b000, exp_db}) begin
        errors++; $display("FAIL single_db edge %0d got %b exp %b", k, btn_db, exp_db);
      end
      checks++;
      if (pending !== {3'b000, exp_pend}) begin
        errors++; $display("FAIL single_pending edge %0d got %b exp %b", k, pending, exp_pend);
      end
      checks++;
      if (mv.move_valid !== exp_v) begin
        errors++; $display("FAIL single_valid edge %0d got %b exp %b", k, mv.move_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (mv.move_dir !== DIR_UP) begin
          errors++; $display("FAIL single_dir got %0d exp 0", mv.move_dir);
        end
      end
    end
    btn = 4'd0;
    for (int k = 0; k < 2 + DB + 4; k++) tick();
    checks++;
    if (btn_db !== 4'd0) begin
      errors++; $display("FAIL single_release got %b exp 0000", btn_db);
    end
    checks++;
    if (acc_dir.size() != 1) begin
      errors++; $display("FAIL single_count got %0d exp 1", acc_dir.size());
    end
  endtask

  task automatic test_bounce();
    acc_dir.delete();
    for (int k = 0; k < 20; k++) begin
      btn[2] = ((k / 2) % 2) == 0;
      tick();
      checks++;
      if (btn_db !== 4'd0 || pending !== 4'd0 || mv.move_valid !== 1'b0) begin
        errors++;
        $display("FAIL bounce cycle %0d got db=%b pend=%b valid=%b exp 0000/0000/0",
                 k, btn_db, pending, mv.move_valid);
      end
    end
    btn = 4'd0;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (acc_dir.size() != 0 || btn_db !== 4'd0) begin
      errors++; $display("FAIL bounce_final got moves=%0d db=%b exp 0/0000", acc_dir.size(), btn_db);
    end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    btn = 4'b0110;
    n = 0;
    while (acc_dir.size() < 2 && n < 60) begin tick(); n++; end
    btn = 4'd0;
    for (int k = 0; k < 12; k++) tick();
    btn = 4'b0011;
    n = 0;
    while (acc_dir.size() < 4 && n < 60) begin tick(); n++; end
    btn = 4'd0;
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (acc_dir.size() != 4) begin
      errors++; $display("FAIL rr_count got %0d exp 4", acc_dir.size());
    end else begin
      checks++;
      if (acc_dir[0] != 1 || acc_dir[1] != 2 || acc_dir[2] != 0 || acc_dir[3] != 1) begin
        errors++;
        $display("FAIL rr_order got %0d,%0d,%0d,%0d exp 1,2,0,1",
                 acc_dir[0], acc_dir[1], acc_dir[2], acc_dir[3]);
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != LO + 2) begin
        errors++; $display("FAIL rr_gap got %0d exp %0d", acc_cyc[1] - acc_cyc[0], LO + 2);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    acc_dir.delete();
    mv.move_ready = 1'b0;
    @(posedge clk);
    #1;
    btn = 4'b0001;
    tick();
    tick();
    btn = 4'b1001;
    n = 0;
    while (mv.move_valid !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (mv.move_valid !== 1'b1) begin
      errors++; $display("FAIL stall_offer got valid=%b exp 1", mv.move_valid);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (mv.move_valid !== 1'b1 || mv.move_dir !== DIR_UP) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b dir=%0d exp 1/0", k, mv.move_valid,
                 mv.move_dir);
      end
    end
    checks++;
    if (pending !== 4'b1001) begin
      errors++; $display("FAIL stall_pending got %b exp 1001", pending);
    end
    mv.move_ready = 1'b1;
    n = 0;
    while (acc_dir.size() < 2 && n < 60) begin tick(); n++; end
    btn = 4'd0;
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (acc_dir.size() != 2) begin
      errors++; $display("FAIL stall_count got %0d exp 2", acc_dir.size());
    end else begin
      checks++;
      if (acc_dir[0] != 0 || acc_dir[1] != 3) begin
        errors++; $display("FAIL stall_order got %0d,%0d exp 0,3", acc_dir[0], acc_dir[1]);
      end
    end
  endtask

  task automatic test_game_over();
    int n;
    acc_dir.delete();
    mv.move_ready = 1'b0;
    btn = 4'b1001;
    n = 0;
    while (mv.move_valid !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (mv.move_valid !== 1'b1 || pending !== 4'b1001 || mv.move_dir !== DIR_UP) begin
      errors++;
      $display("FAIL go_setup got valid=%b pend=%b dir=%0d exp 1/1001/0", mv.move_valid, pending,
               mv.move_dir);
    end
    game_over = 1'b1;
    tick();
    checks++;
    if (mv.move_valid !== 1'b0 || pending !== 4'd0) begin
      errors++; $display("FAIL go_drop got valid=%b pend=%b exp 0/0000", mv.move_valid, pending);
    end
    btn = 4'd0;
    for (int k = 0; k < 2 + DB + 2; k++) tick();
    btn = 4'b0010;
    for (int k = 0; k < 2 + DB + 4; k++) begin
      tick();
      checks++;
      if (pending !== 4'd0 || mv.move_valid !== 1'b0) begin
        errors++;
        $display("FAIL go_press cycle %0d got pend=%b valid=%b exp 0000/0", k, pending,
                 mv.move_valid);
      end
    end
    btn = 4'd0;
    for (int k = 0; k < 2 + DB + 4; k++) tick();
    game_over = 1'b0;
    mv.move_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (acc_dir.size() != 0 || pending !== 4'd0) begin
      errors++; $display("FAIL go_after got moves=%0d pend=%b exp 0/0000", acc_dir.size(), pending);
    end
  endtask

  task automatic test_async_reset();
    int n;
    acc_dir.delete();
    mv.move_ready = 1'b1;
    btn = 4'b0100;
    n = 0;
    while (acc_dir.size() < 1 && n < 40) begin tick(); n++; end
    btn = 4'd0;
    for (int k = 0; k < 12; k++) tick();
    mv.move_ready = 1'b0;
    btn = 4'b0010;
    n = 0;
    while (mv.move_valid !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (mv.move_valid !== 1'b1 || btn_db !== 4'b0010) begin
      errors++; $display("FAIL arst_setup got valid=%b db=%b exp 1/0010", mv.move_valid, btn_db);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (mv.move_valid !== 1'b0 || pending !== 4'd0 || btn_db !== 4'd0) begin
      errors++;
      $display("FAIL arst_immediate got valid=%b pend=%b db=%b exp 0/0000/0000", mv.move_valid,
               pending, btn_db);
    end
    btn = 4'd0;
    #2;
    rst = 1'b0;
    tick();
    tick();
    acc_dir.delete();
    mv.move_ready = 1'b1;
    btn = 4'b1010;
    n = 0;
    while (acc_dir.size() < 2 && n < 60) begin tick(); n++; end
    btn = 4'd0;
    for (int k = 0; k < 12; k++) tick();
    checks++;
    if (acc_dir.size() != 2) begin
      errors++; $display("FAIL arst_count got %0d exp 2", acc_dir.size());
    end else begin
      checks++;
      if (acc_dir[0] != 1 || acc_dir[1] != 3) begin
        errors++; $display("FAIL arst_order got %0d,%0d exp 1,3", acc_dir[0], acc_dir[1]);
      end
    end
  endtask

  task automatic test_random();
    int exp_q[$];
    int model_ptr;
    int remaining;
    int hold;
    int t;
    int d;
    do_reset();
    model_ptr = 0;
    for (int round = 0; round < 8; round++) begin
      acc_dir.delete();
      acc_cyc.delete();
      exp_q.delete();
      remaining = int'($urandom_range(1, 15));
      hold = int'($urandom_range(8, 20));
      btn = 4'(remaining);
      // All bits debounce together, so they are served in round-robin order.
      while (remaining != 0) begin
        for (int off = 0; off < 4; off++) begin
          d = (model_ptr + off) % 4;
          if (remaining[d]) begin
            exp_q.push_back(d);
            remaining[d] = 1'b0;
            model_ptr = (d + 1) % 4;
            break;
          end
        end
      end
      t = 0;
      while ((acc_dir.size() < exp_q.size() || t < hold) && t < 400) begin
        mv.move_ready = (t > 200) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        t++;
        if (t == hold) btn = 4'd0;
      end
      btn = 4'd0;
      mv.move_ready = 1'b1;
      for (int k = 0; k < LO + 10; k++) tick();
      checks++;
      if (acc_dir.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_count round %0d got %0d exp %0d", round, acc_dir.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (acc_dir[i] != exp_q[i]) begin
            errors++;
            $display("FAIL rand_dir round %0d move %0d got %0d exp %0d", round, i, acc_dir[i],
                     exp_q[i]);
          end
          if (i > 0) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] < LO + 2) begin
              errors++;
              $display("FAIL rand_gap round %0d move %0d got %0d exp >=%0d", round, i,
                       acc_cyc[i] - acc_cyc[i-1], LO + 2);
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 4'd0;
    game_over = 1'b0;
    mv.move_ready = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_round_robin();
    test_stall();
    test_game_over();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Sits between the IO-shield direction buttons and game_loop, and owns the single "move" port into the game datapath.
- Synchronises and debounces the four direction buttons, then latches each press as a pending request.
- Arbitrates pending requests round-robin and issues one move at a time over a valid/ready handshake.
- After each accepted move, enforces a lockout interval before the next grant, so one press never produces multiple tile steps.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles the synchronised input must differ from the debounced level before that level flips (10 ms at 50 MHz); must be ≥1.
- LOCKOUT_CYCLES, 2500000, idle cycles after an accepted move before the next grant (50 ms); 0 means no lockout.

Ports:
- clk  input  1  50 MHz system clock
- rst  input  1  asynchronous, active-high reset
- btn  input  4  raw buttons: [0]=up, [1]=down, [2]=left, [3]=right; active high
- game_over  input  1  high while win/lose is displayed; suppresses all moves
- move_ready  input  1  game datapath can accept a move this cycle
- move_valid  output  1  a move is offered
- move_dir  output  2  direction of the offered move; encoding is the btn index
- pending  output  4  current pending request bits (debug)
- btn_db  output  4  debounced button levels (debug)

Behaviour:
- Reset (async, immediate): move_valid=0, move_dir=0, pending=0, btn_db=0, both sync stages=0, all counters=0, state=IDLE, rr_ptr=0.
- Synchronizer: 2 flops per button; sync[i] is raw btn delayed 2 edges.
- Debounce, per button:
  - While sync[i]==btn_db[i], count=0.
  - Otherwise count increments each cycle.
  - When count==DEBOUNCE_CYCLES-1 and sync still differs, btn_db[i] flips and count=0.
  - A single cycle of agreement resets count to 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Request capture:
  - pending[i] is set on the same edge btn_db[i] flips 0->1, unless game_over=1.
  - A release sets nothing.
  - A repeat press of a direction already pending coalesces into the one bit.
  - If set and clear of the same bit hit the same edge, set wins.
- Arbitration: search pending starting at rr_ptr, ascending mod 4; the first set bit is the winner.
- FSM states:
  - IDLE: if pending!=0 and game_over=0, latch move_dir=winner, assert move_valid, go to OFFER.
  - OFFER:
    - move_valid and move_dir are held stable until move_ready=1; later-arriving requests never change move_dir.
    - On move_valid & move_ready: clear pending[move_dir], set rr_ptr=move_dir+1 (2-bit wrap), deassert move_valid next edge.
    - Then go to COOLDOWN, or to IDLE if LOCKOUT_CYCLES==0.
  - COOLDOWN:
    - Counter runs 0..LOCKOUT_CYCLES-1, then IDLE; move_valid=0 throughout.
    - Presses are still captured into pending during cooldown.
- game_over=1 in any state:
  - pending is cleared each cycle.
  - In OFFER, move_valid drops on the next edge and the FSM goes to IDLE without a handshake; rr_ptr is unchanged.
  - In COOLDOWN, the countdown continues normally.
- Latency: with raw btn stable high before edge 0, btn_db and pending rise at edge 2+DEBOUNCE_CYCLES and move_valid rises at edge 3+DEBOUNCE_CYCLES.
- Exactly one accepted move per debounced press; a held button never repeats.

Decomposition:
- Shared package game_pkg holds:
  - DIR_UP=2'd0, DIR_DOWN=2'd1, DIR_LEFT=2'd2, DIR_RIGHT=2'd3 (also used by game_loop).
  - FSM state encoding: IDLE, OFFER, COOLDOWN.
- One sub-module, button_debouncer: 2-flop synchronizer plus counter, parameter DEBOUNCE_CYCLES, outputs level and rise pulse. Four instances via generate.
- Arbiter and FSM stay in move_arbiter.

Test Plan (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=3, move_ready=1 unless stated):
1. btn=4'b0001 held from edge 0 -> btn_db[0]=pending[0]=1 at edge 6; move_valid=1, move_dir=0 at edge 7 for exactly 1 cycle; valid=0 for 3 cooldown cycles; no second move while held.
2. btn[2] toggles every 2 cycles for 20 cycles, then low -> btn_db[2] stays 0, pending stays 0, move_valid never asserts.
3. btn=4'b0110 pressed together from reset -> moves down(1), then left(2) after cooldown, rr_ptr=3. Release, then press 4'b0011 -> up(0) granted before down(1).
4. move_ready=0 for 5 cycles after valid rises, btn[3] pressed meanwhile -> move_dir stays 0 and valid stays high. On ready, up accepted; right follows after cooldown.
5. game_over=1 while in OFFER with pending=4'b1001 -> move_valid=0 next edge, pending=0. A press during game_over never sets pending.
6. rst pulsed while in OFFER, asserted between clock edges -> move_valid, pending, btn_db go 0 without a clock edge. After release, the FSM is IDLE and rr_ptr=0.
